// File: rtl/cache_miss_arbiter.sv
// rtl/cache_miss_arbiter.sv - shares one L2/bus port between the L1 I-cache and D-cache
// Optional statistics counters are enabled by defining ARB_STATS_EN.
module cache_miss_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int MAX_WAIT    = 4,
  parameter int RSP_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_req_ready,
  input  logic              d_req_valid,
  input  logic [1:0]        d_req_op,
  input  logic [ADDR_W-1:0] d_req_addr,
  output logic              d_req_ready,
  output logic              bus_valid,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_src,
  input  logic              bus_ready,
  input  logic              bus_rsp_valid,
  output logic              i_rsp_valid,
  output logic              d_rsp_valid,
  output logic              rsp_timeout,
  output logic              busy
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt,
  output logic [CNT_W-1:0]  wb_cnt,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_WB   = 2'b10;
  localparam int         TW      = $clog2(RSP_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t        state;
  logic          last_grant;
  logic [3:0]    i_wait;
  logic [3:0]    d_wait;
  logic [TW-1:0] tmo_cnt;
  logic          d_wb;
  logic          i_force;
  logic          d_force;
  logic          grant_d;
  logic          tmo_hit;
  logic          rsp_hit;

  assign d_wb    = d_req_valid && (d_req_op == OP_WB);
  assign i_force = i_req_valid && (i_wait == 4'(MAX_WAIT));
  assign d_force = d_req_valid && (d_wait == 4'(MAX_WAIT));

  // A starved requester outranks a writeback so that a continuous writeback
  // stream cannot hold off an I fetch for more than MAX_WAIT arbitrations.
  always_comb begin
    grant_d = 1'b0;
    if (i_force && !d_force)
      grant_d = 1'b0;
    else if (d_force && !i_force)
      grant_d = 1'b1;
    else if (d_wb)
      grant_d = 1'b1;
    else if (i_req_valid && d_req_valid)
      grant_d = !last_grant;
    else
      grant_d = d_req_valid;
  end

  assign i_req_ready = rst_n && (state == IDLE) && i_req_valid && !grant_d;
  assign d_req_ready = rst_n && (state == IDLE) && d_req_valid && grant_d;

  assign tmo_hit     = (tmo_cnt == TW'(RSP_TIMEOUT - 1));
  assign rsp_hit     = (state == WAIT_RSP) && bus_rsp_valid;
  assign i_rsp_valid = rsp_hit && !bus_src;
  assign d_rsp_valid = rsp_hit && bus_src;
  assign rsp_timeout = (state == WAIT_RSP) && !bus_rsp_valid && tmo_hit;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      i_wait     <= '0;
      d_wait     <= '0;
      tmo_cnt    <= '0;
      bus_valid  <= 1'b0;
      bus_op     <= OP_READ;
      bus_addr   <= '0;
      bus_src    <= 1'b0;
    end else begin
      if (!i_req_valid || i_req_ready)
        i_wait <= '0;
      else if (state == IDLE && i_wait != 4'(MAX_WAIT))
        i_wait <= i_wait + 4'd1;

      if (!d_req_valid || d_req_ready)
        d_wait <= '0;
      else if (state == IDLE && d_wait != 4'(MAX_WAIT))
        d_wait <= d_wait + 4'd1;

      case (state)
        IDLE: begin
          if (i_req_ready || d_req_ready) begin
            state      <= ISSUE;
            last_grant <= grant_d;
            bus_valid  <= 1'b1;
            bus_src    <= grant_d;
            bus_addr   <= grant_d ? d_req_addr : i_req_addr;
            bus_op     <= (!grant_d || d_req_op == 2'b11) ? OP_READ : d_req_op;
          end
        end
        ISSUE: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            tmo_cnt   <= '0;
            state     <= (bus_op == OP_WB) ? IDLE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (bus_rsp_valid || tmo_hit)
            state <= IDLE;
          else
            tmo_cnt <= tmo_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
      wb_cnt      <= '0;
      stall_cnt   <= '0;
    end else begin
      if (i_req_ready && i_grant_cnt != '1)
        i_grant_cnt <= i_grant_cnt + 1'b1;
      if (d_req_ready && d_grant_cnt != '1)
        d_grant_cnt <= d_grant_cnt + 1'b1;
      if (d_req_ready && d_wb && wb_cnt != '1)
        wb_cnt <= wb_cnt + 1'b1;
      // Nonzero only if IDLE ever leaves a pending request unserved.
      if (state == IDLE && (i_req_valid || d_req_valid) && !i_req_ready && !d_req_ready
          && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// tb/tb_cache_miss_arbiter.sv - scoreboard bench for cache_miss_arbiter
module tb_cache_miss_arbiter;

  localparam int AW = 32;
  localparam int RT = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req_valid;
  logic [AW-1:0] i_req_addr;
  logic          i_req_ready;
  logic          d_req_valid;
  logic [1:0]    d_req_op;
  logic [AW-1:0] d_req_addr;
  logic          d_req_ready;
  logic          bus_valid;
  logic [1:0]    bus_op;
  logic [AW-1:0] bus_addr;
  logic          bus_src;
  logic          bus_ready;
  logic          bus_rsp_valid = 1'b0;
  logic          i_rsp_valid;
  logic          d_rsp_valid;
  logic          rsp_timeout;
  logic          busy;

  always #5 clk = ~clk;

  cache_miss_arbiter #(.ADDR_W(AW), .MAX_WAIT(4), .RSP_TIMEOUT(RT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .d_req_valid(d_req_valid), .d_req_op(d_req_op), .d_req_addr(d_req_addr),
    .d_req_ready(d_req_ready),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr), .bus_src(bus_src),
    .bus_ready(bus_ready), .bus_rsp_valid(bus_rsp_valid),
    .i_rsp_valid(i_rsp_valid), .d_rsp_valid(d_rsp_valid), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  typedef struct packed {logic src; logic [1:0] op; logic [AW-1:0] addr;} cmd_t;

  int         errors = 0;
  int         checks = 0;
  cmd_t       exp_bus[$];
  logic [2:0] exp_rsp[$];   // {rsp_timeout, d_rsp_valid, i_rsp_valid}
  bit         auto_rsp = 1'b1;
  int         rsp_delay = 2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    cmd_t e;
    if (rst_n) begin
      if (bus_valid && bus_ready) begin
        if (exp_bus.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: got %0h expected none", {bus_src, bus_op, bus_addr});
        end else begin
          e = exp_bus.pop_front();
          chk("bus_cmd", {bus_src, bus_op, bus_addr}, e);
        end
      end
      if (i_rsp_valid || d_rsp_valid || rsp_timeout) begin
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got %0b expected none",
                   {rsp_timeout, d_rsp_valid, i_rsp_valid});
        end else begin
          chk("rsp_route", {rsp_timeout, d_rsp_valid, i_rsp_valid}, exp_rsp.pop_front());
        end
      end
    end
  end

  // Bus model: returns a line fill rsp_delay cycles after each non-writeback command
  always begin
    @(negedge clk);
    if (rst_n && auto_rsp && bus_valid && bus_ready && bus_op != 2'b10) begin
      @(posedge clk);
      repeat (rsp_delay) @(posedge clk);
      #1 bus_rsp_valid = 1'b1;
      @(posedge clk);
      #1 bus_rsp_valid = 1'b0;
    end
  end

  task automatic i_send(input logic [AW-1:0] a);
    int n = 0;
    i_req_valid = 1'b1;
    i_req_addr  = a;
    @(negedge clk);
    while (!i_req_ready && n < 1000) begin n++; @(negedge clk); end
    chk("i_accept_bound", 64'(n < 1000), 1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic d_send(input logic [1:0] op, input logic [AW-1:0] a);
    int n = 0;
    d_req_valid = 1'b1;
    d_req_op    = op;
    d_req_addr  = a;
    @(negedge clk);
    while (!d_req_ready && n < 1000) begin n++; @(negedge clk); end
    chk("d_accept_bound", 64'(n < 1000), 1);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || exp_bus.size() != 0 || exp_rsp.size() != 0) && n < 2000) begin
      n++; @(negedge clk);
    end
    chk("drain_bound", 64'(n < 2000), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_op = 2'b00; d_req_addr = '0;
    bus_ready   = 1'b1;

    #12;
    chk("reset_outputs", {bus_valid, bus_src, bus_op, bus_addr, busy,
                          i_rsp_valid, d_rsp_valid, rsp_timeout, i_req_ready, d_req_ready}, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Round-robin from reset: I first (last_grant = D), then alternating
    exp_bus.push_back({1'b0, 2'b00, 32'h1111_0000});
    exp_bus.push_back({1'b1, 2'b00, 32'h2222_0000});
    exp_bus.push_back({1'b0, 2'b00, 32'h1111_0040});
    exp_bus.push_back({1'b1, 2'b00, 32'h2222_0040});
    exp_rsp.push_back(3'b001); exp_rsp.push_back(3'b010);
    exp_rsp.push_back(3'b001); exp_rsp.push_back(3'b010);
    fork
      begin i_send(32'h1111_0000); i_send(32'h1111_0040); end
      begin d_send(2'b00, 32'h2222_0000); d_send(2'b00, 32'h2222_0040); end
    join
    wait_idle();

    // Single I read with a stalled bus: command held stable
    bus_ready = 1'b0;
    exp_bus.push_back({1'b0, 2'b00, 32'hABCD_EF00});
    exp_rsp.push_back(3'b001);
    i_send(32'hABCD_EF00);
    chk("i_issue_next_cycle", {bus_valid, bus_src, bus_op}, {1'b1, 1'b0, 2'b00});
    repeat (2) @(posedge clk); #1;
    chk("issue_hold", {bus_valid, busy, bus_addr}, {1'b1, 1'b1, 32'hABCD_EF00});
    bus_ready = 1'b1;
    wait_idle();

    // Writeback beats I read and is posted straight back to IDLE
    exp_bus.push_back({1'b1, 2'b10, 32'h1234_5640});
    exp_bus.push_back({1'b0, 2'b00, 32'h3333_0000});
    exp_rsp.push_back(3'b001);
    fork
      d_send(2'b10, 32'h1234_5640);
      i_send(32'h3333_0000);
      begin
        n = 0;
        @(negedge clk);
        while (!(bus_valid && bus_ready && bus_op == 2'b10) && n < 200) begin
          n++; @(negedge clk);
        end
        chk("wb_seen_bound", 64'(n < 200), 1);
        @(posedge clk); #1;
        chk("wb_posted_idle", busy, 0);
      end
    join
    wait_idle();

    // Five back-to-back writebacks: I is force-granted after four losses
    for (int k = 0; k < 4; k++) exp_bus.push_back({1'b1, 2'b10, 32'h4000_0000 + 32'(k * 64)});
    exp_bus.push_back({1'b0, 2'b00, 32'h5000_0000});
    exp_bus.push_back({1'b1, 2'b10, 32'h4000_0100});
    exp_rsp.push_back(3'b001);
    fork
      for (int k = 0; k < 5; k++) d_send(2'b10, 32'h4000_0000 + 32'(k * 64));
      i_send(32'h5000_0000);
    join
    wait_idle();

    // Reserved op is issued as a read
    exp_bus.push_back({1'b1, 2'b00, 32'h6666_0080});
    exp_rsp.push_back(3'b010);
    d_send(2'b11, 32'h6666_0080);
    wait_idle();

    // RWIM with no response: timeout after RT cycles in WAIT_RSP
    auto_rsp = 1'b0;
    exp_bus.push_back({1'b1, 2'b01, 32'h8765_4300});
    exp_rsp.push_back(3'b100);
    d_send(2'b01, 32'h8765_4300);
    n = 0;
    @(negedge clk);
    while (!(bus_valid && bus_ready) && n < 100) begin n++; @(negedge clk); end
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_timeout && cyc < RT + 10);
    chk("timeout_cycle", cyc, RT);
    @(posedge clk); #1;
    chk("timeout_busy_after", busy, 0);
    auto_rsp = 1'b1;
    wait_idle();

    // Response arriving in the timeout cycle wins
    rsp_delay = RT - 1;
    exp_bus.push_back({1'b1, 2'b00, 32'h7777_0000});
    exp_rsp.push_back(3'b010);
    d_send(2'b00, 32'h7777_0000);
    wait_idle();
    rsp_delay = 2;

    // Reset while in ISSUE: bus_valid drops asynchronously
    bus_ready = 1'b0;
    d_send(2'b00, 32'h5555_0000);
    chk("pre_reset_issue", bus_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_drop", {bus_valid, busy}, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    bus_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", {busy, bus_valid}, 0);

    // last_grant back to D after reset: I wins the tie
    exp_bus.push_back({1'b0, 2'b00, 32'h9999_0000});
    exp_bus.push_back({1'b1, 2'b00, 32'hAAAA_0000});
    exp_rsp.push_back(3'b001); exp_rsp.push_back(3'b010);
    fork
      i_send(32'h9999_0000);
      d_send(2'b00, 32'hAAAA_0000);
    join
    wait_idle();

    chk("scoreboard_empty", 64'(exp_bus.size() + exp_rsp.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
